hysteresis_scanner: RTL
=======================

Name: hysteresis_scanner

Overview:
Read side of the hysteresis BRAM. Waits for the single-cycle hough_start pulse from the hysteresis stage, then walks the reduced-image BRAM in raster order. For every surviving edge pixel it pushes that pixel's full-image (x,y) coordinate into the FIFO that feeds the Hough accumulator. It then pulses scan_done so the accumulator knows the point stream for this frame is complete.

Parameters:
REDUCED_IMAGE_SIZE, 233910, number of BRAM entries (REDUCED_WIDTH*REDUCED_HEIGHT)
REDUCED_WIDTH, 1035, columns in the reduced image
REDUCED_HEIGHT, 226, rows in the reduced image
WIDTH, 1280, full image width; X_WIDTH = $clog2(WIDTH) = 11
HEIGHT, 720, full image height; Y_WIDTH = $clog2(HEIGHT) = 10
STARTING_X, 123, full-image x of reduced column 0
STARTING_Y, 31, full-image y of reduced row 0
MIN_VALUE, 0, a pixel is emitted when its BRAM value is strictly greater than this

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
hough_start  in  1  one-cycle pulse: BRAM frame is complete
rd_addr  out  $clog2(REDUCED_IMAGE_SIZE)  BRAM read address; BRAM read latency is 1 cycle
rd_data  in  8  BRAM read data for the address presented on the previous cycle
out_wr_en  out  1  coordinate FIFO write enable
out_full  in  1  coordinate FIFO full
out_din  out  X_WIDTH+Y_WIDTH  {x[10:0], y[9:0]}, full-image coordinate
scan_busy  out  1  high from the cycle after the start pulse until scan_done
scan_done  out  1  one-cycle pulse when the frame scan is complete

Behaviour:
- Reset is synchronous and active-high, on the single clock.
- Registered state: state, addr_q, valid_q, col, row. Reset values: state=IDLE, addr_q=0, valid_q=0, col=0, row=0.
- While in IDLE (including after reset), all outputs read 0: rd_addr, out_wr_en, out_din, scan_busy, scan_done.
- States are IDLE, SCAN, DONE.
- IDLE:
  - rd_addr=0.
  - On hough_start=1, go to SCAN next cycle with addr_q=0 and valid_q=0.
- SCAN, per cycle:
  - valid_q=1 means rd_data holds the pixel at addr_q, i.e. (col,row).
  - hit = valid_q & (rd_data > MIN_VALUE).
  - stall = hit & out_full.
  - If stall: out_wr_en=0; rd_addr=addr_q, re-presenting the same address so rd_data remains valid next cycle; col, row and addr_q hold.
  - Else: out_wr_en=hit; out_din={X_WIDTH'(col+STARTING_X), Y_WIDTH'(row+STARTING_Y)}.
  - Else, advancing: if valid_q, advance col/row; col wraps at REDUCED_WIDTH-1 to 0 with row+1.
  - Else, addressing: rd_addr=addr_q+valid_q, and addr_q takes that value; valid_q becomes 1.
  - The first SCAN cycle only primes the read (valid_q=0, rd_addr=0).
  - When the last pixel is consumed without a stall (valid_q, col=REDUCED_WIDTH-1, row=REDUCED_HEIGHT-1), go to DONE. No read beyond REDUCED_IMAGE_SIZE-1 is ever issued.
- DONE: scan_done=1 for exactly one cycle; reset col, row, addr_q and valid_q to 0; return to IDLE.
- scan_busy=1 in SCAN and DONE.
- Throughput: one pixel per cycle when not stalled. With no stalls, scan_done asserts exactly PIXEL_COUNT+2 cycles after the hough_start cycle.
- out_wr_en, out_din, rd_addr and scan_done are combinational from registered state, rd_data and out_full. out_wr_en never asserts while out_full=1.
- hough_start while in SCAN or DONE is ignored and not queued.
- Reset mid-scan: the next cycle is IDLE with all outputs 0; the partial frame is abandoned and no scan_done is produced.
- Coordinate arithmetic is truncated to X_WIDTH/Y_WIDTH. Defaults never overflow: max x=1157, max y=256.

Optional Feature:
SCANNER_EDGE_COUNT_EN:
- Defined: adds output port edge_count [$clog2(REDUCED_IMAGE_SIZE+1)-1:0].
  - Cleared on reset and on entry to SCAN.
  - Increments on every out_wr_en.
  - Holds its final value from scan_done until the next start; lets the accumulator normalise votes.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Overrides REDUCED_WIDTH=4, REDUCED_HEIGHT=3, STARTING_X=123, STARTING_Y=31. BRAM all 0; pulse hough_start -> zero FIFO writes; scan_done exactly 14 cycles after the start cycle; scan_busy high for 14 cycles.
- Same overrides, BRAM[5]=60, BRAM[11]=13, others 0 -> exactly two writes: {x=124,y=32} then {x=126,y=33}; with SCANNER_EDGE_COUNT_EN, edge_count=2.
- Same overrides, all BRAM=255, out_full held 1 for 5 cycles starting at the first hit -> rd_addr stays 0 during the stall; 12 writes in raster order with none lost or duplicated; scan_done 19 cycles after start.
- MIN_VALUE=20, BRAM[0]=20, BRAM[1]=21 -> only {x=124,y=31} written.
- hough_start re-pulsed mid-scan -> ignored, single scan_done. reset asserted at pixel 6 -> next cycle IDLE, no further writes, no scan_done; a new start scans the full frame from address 0.

Source files
------------

// File: rtl/hysteresis_scanner.sv
// rtl/hysteresis_scanner.sv - raster walk of the hysteresis BRAM, emitting edge-pixel coordinates to the Hough FIFO
// Optional edge counter port enabled by defining SCANNER_EDGE_COUNT_EN.
module hysteresis_scanner #(
  parameter int REDUCED_IMAGE_SIZE = 233910,
  parameter int REDUCED_WIDTH      = 1035,
  parameter int REDUCED_HEIGHT     = 226,
  parameter int WIDTH              = 1280,
  parameter int HEIGHT             = 720,
  parameter int STARTING_X         = 123,
  parameter int STARTING_Y         = 31,
  parameter int MIN_VALUE          = 0,
  localparam int AW                = $clog2(REDUCED_IMAGE_SIZE),
  localparam int X_WIDTH           = $clog2(WIDTH),
  localparam int Y_WIDTH           = $clog2(HEIGHT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       hough_start,
  output logic [AW-1:0]              rd_addr,
  input  logic [7:0]                 rd_data,
  output logic                       out_wr_en,
  input  logic                       out_full,
  output logic [X_WIDTH+Y_WIDTH-1:0] out_din,
  output logic                       scan_busy,
  output logic                       scan_done
`ifdef SCANNER_EDGE_COUNT_EN
  ,output logic [$clog2(REDUCED_IMAGE_SIZE+1)-1:0] edge_count
`endif
);

  localparam int CW = (REDUCED_WIDTH > 1) ? $clog2(REDUCED_WIDTH) : 1;
  localparam int RW = (REDUCED_HEIGHT > 1) ? $clog2(REDUCED_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(REDUCED_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(REDUCED_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          valid_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          hit, stall, last;

  // On the last pixel the address is held so no read past the frame is issued.
  always_comb begin
    hit    = (state == SCAN) && valid_q && (int'(rd_data) > MIN_VALUE);
    stall  = hit && out_full;
    last   = valid_q && (col == LAST_COL) && (row == LAST_ROW);
    addr_n = (stall || last) ? addr_q : addr_q + AW'(valid_q);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (hough_start) state_n = SCAN;
      SCAN:    if (last && !stall) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_addr   = '0;
    out_wr_en = 1'b0;
    out_din   = '0;
    scan_busy = 1'b0;
    scan_done = 1'b0;
    case (state)
      SCAN: begin
        scan_busy = 1'b1;
        rd_addr   = addr_n;
        out_wr_en = hit && !stall;
        if (!stall)
          out_din = {X_WIDTH'(int'(col) + STARTING_X), Y_WIDTH'(int'(row) + STARTING_Y)};
      end
      DONE: begin
        scan_busy = 1'b1;
        scan_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || state != SCAN) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else if (!stall) begin
      addr_q  <= addr_n;
      valid_q <= 1'b1;
      if (valid_q) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef SCANNER_EDGE_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)                            edge_count <= '0;
    else if (state == IDLE && hough_start) edge_count <= '0;
    else if (out_wr_en)                    edge_count <= edge_count + 1'b1;
  end
`endif

endmodule
